exe_mem_stage_buf: RTL

- Parametrised EX→MEM pipeline boundary for the next-generation core; replaces the fixed 16-bit, always-advancing EX/MEM register.
- Two-entry skid buffer with valid/ready handshake, so MEM back-pressure does not need a combinational stall path into EX.
- Supports flush (branch/exception squash), valid-qualified control outputs, optional suppression of writes to register 0, and a forwarding tap for the EX-stage bypass mux.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/exe_mem_stage_buf_slot.sv | 26 ++
 rtl/exe_mem_stage_buf.sv | 111 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types for the EX/MEM boundary.
package pipe_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int RADDR_W_DEF = 4;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]  alu_result;
    logic [DATA_W_DEF-1:0]  rdata2;
    logic                   mem_wen;
    logic                   mem_ren;
    logic                   mem_to_reg;
    logic                   reg_wen;
    logic [RADDR_W_DEF-1:0] reg_waddr;
  } exe_mem_t;

endpackage

// File: rtl/exe_mem_stage_buf_slot.sv
// Single valid+payload register; load wins over clear.
module pipe_skid_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/exe_mem_stage_buf.sv
// EX->MEM two-entry skid buffer with flush and bypass tap.
module exe_mem_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RADDR_W  = RADDR_W_DEF,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [DATA_W-1:0]  rdata2,
  input  logic               mem_wen,
  input  logic               mem_ren,
  input  logic               mem_to_reg,
  input  logic               reg_wen,
  input  logic [RADDR_W-1:0] reg_waddr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  alu_result_out,
  output logic [DATA_W-1:0]  rdata2_out,
  output logic               mem_wen_out,
  output logic               mem_ren_out,
  output logic               mem_to_reg_out,
  output logic               reg_wen_out,
  output logic [RADDR_W-1:0] reg_waddr_out,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_waddr,
  output logic [DATA_W-1:0]  fwd_data
);

  typedef struct packed {
    logic [DATA_W-1:0]  alu_result;
    logic [DATA_W-1:0]  rdata2;
    logic               mem_wen;
    logic               mem_ren;
    logic               mem_to_reg;
    logic               reg_wen;
    logic [RADDR_W-1:0] reg_waddr;
  } pay_t;

  localparam int PW = $bits(pay_t);

  pay_t in_pay, head_q, skid_q, head_d;
  logic head_v, skid_v;
  logic accept, head_free;
  logic head_load, head_clear;
  logic skid_load, skid_clear;
  logic wen_keep;

  assign wen_keep = !ZERO_REG || (reg_waddr != '0);

  always_comb begin
    in_pay            = '0;
    in_pay.alu_result = alu_result;
    in_pay.rdata2     = rdata2;
    in_pay.mem_wen    = mem_wen;
    in_pay.mem_ren    = mem_ren;
    in_pay.mem_to_reg = mem_to_reg;
    in_pay.reg_wen    = reg_wen & wen_keep;
    in_pay.reg_waddr  = reg_waddr;
  end

  assign in_ready  = !skid_v;
  assign accept    = in_valid & in_ready;
  assign head_free = !head_v | out_ready;

  // skid always refills the head first to keep FIFO order
  assign head_d     = skid_v ? skid_q : in_pay;
  assign head_load  = !flush & head_free & (skid_v | accept);
  assign head_clear = flush | (head_free & !skid_v & !accept);
  assign skid_load  = !flush & !head_free & accept;
  assign skid_clear = flush | (head_free & skid_v);

  pipe_skid_slot #(.W(PW)) u_head (
    .clk   (clk),
    .rst   (rst),
    .load  (head_load),
    .clear (head_clear),
    .d     (head_d),
    .valid (head_v),
    .q     (head_q)
  );

  pipe_skid_slot #(.W(PW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_pay),
    .valid (skid_v),
    .q     (skid_q)
  );

  assign out_valid      = head_v;
  assign alu_result_out = head_q.alu_result;
  assign rdata2_out     = head_q.rdata2;
  assign reg_waddr_out  = head_q.reg_waddr;
  assign mem_wen_out    = head_q.mem_wen & head_v;
  assign mem_ren_out    = head_q.mem_ren & head_v;
  assign mem_to_reg_out = head_q.mem_to_reg & head_v;
  assign reg_wen_out    = head_q.reg_wen & head_v;

  assign fwd_valid = out_valid & reg_wen_out & !mem_to_reg_out;
  assign fwd_waddr = reg_waddr_out;
  assign fwd_data  = alu_result_out;

endmodule
